radiant_pulse_gen: RTL and testbench

//  Parametrised multi-channel calibration pulse generator in the sysclk domain; generalises the fixed

---
 rtl/radiant_pulse_gen.sv | 190 +++++++++++++++++++
 tb/tb_radiant_pulse_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/radiant_pulse_gen.sv
// radiant_pulse_gen
//   Multi-channel calibration pulse generator in the sysclk domain. Each start
//   launches a continuous, N-pulse burst or single-shot train of pulses with a
//   programmable period and high time, gated per channel by a mask. The
//   configuration is captured into shadow registers at start, so live register
//   writes never disturb a running train.
//
//   Optional feature macro: PULSE_GEN_SYNC_ALIGN_EN
//     Adds sync_i. ARM waits for sync_i, and each period restart holds at the
//     last count until sync_i, aligning pulses to the global sync.
//
// Ports
//   clk_i         sysclk, all logic on its rising edge
//   rst_n_i       synchronous active-low reset
//   cfg_mode_i    0=off 1=continuous 2=burst 3=single
//   cfg_period_i  period = cfg_period_i+1 cycles (0 treated as 1)
//   cfg_width_i   high time in cycles (clamped to leave one low cycle)
//   cfg_burst_i   pulses per burst (mode 2)
//   cfg_mask_i    per-channel output enable
//   start_i       1-cycle start strobe
//   stop_i        1-cycle abort strobe (wins over start)
//   sync_i        global sync (only with PULSE_GEN_SYNC_ALIGN_EN)
//   busy_o        high in ARM/RUN
//   done_o        1-cycle strobe on burst/single completion
//   pulse_cnt_o   pulses emitted since last start
//   pulse_o       registered pulse outputs
module radiant_pulse_gen #(
  parameter int NUM_CH      = 2,
  parameter int PERIOD_BITS = 24,
  parameter int WIDTH_BITS  = 16,
  parameter int BURST_BITS  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [PERIOD_BITS-1:0] cfg_period_i,
  input  logic [WIDTH_BITS-1:0]  cfg_width_i,
  input  logic [BURST_BITS-1:0]  cfg_burst_i,
  input  logic [NUM_CH-1:0]      cfg_mask_i,
  input  logic                   start_i,
  input  logic                   stop_i,
`ifdef PULSE_GEN_SYNC_ALIGN_EN
  input  logic                   sync_i,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic [BURST_BITS-1:0]  pulse_cnt_o,
  output logic [NUM_CH-1:0]      pulse_o
);

  // Common width for the width/period comparison
  localparam int CW = (PERIOD_BITS > WIDTH_BITS) ? PERIOD_BITS : WIDTH_BITS;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [PERIOD_BITS-1:0] r_pcnt, w_pcnt_nxt;
  logic [BURST_BITS-1:0]  r_cnt, w_cnt_nxt;
  logic                   w_load;

  // Shadow configuration
  logic [1:0]             r_mode;
  logic [PERIOD_BITS-1:0] r_period;
  logic [CW-1:0]          r_weff;
  logic [BURST_BITS-1:0]  r_burst;
  logic [NUM_CH-1:0]      r_mask;

  logic [NUM_CH-1:0]      r_pulse, w_pulse_nxt;
  logic                   r_busy, r_done;

  logic                   w_sync;
  logic [PERIOD_BITS-1:0] w_per_clamp;
  logic [CW-1:0]          w_per_ext, w_wid_ext, w_weff;
  logic [BURST_BITS-1:0]  w_cnt_inc;
  logic                   w_is_cont;

`ifdef PULSE_GEN_SYNC_ALIGN_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b1;
`endif

  // Period 0 would never leave room for a low cycle, so treat it as 1.
  assign w_per_clamp = (cfg_period_i == '0) ? PERIOD_BITS'(1) : cfg_period_i;
  assign w_per_ext   = CW'(w_per_clamp);
  assign w_wid_ext   = CW'(cfg_width_i);
  // High time capped at P guarantees pcnt==P is always a low cycle.
  assign w_weff      = (w_wid_ext < w_per_ext) ? w_wid_ext : w_per_ext;

  // Saturating increment: continuous mode must never wrap the count.
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + BURST_BITS'(1);
  assign w_is_cont   = (r_mode == MODE_CONT);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_pcnt   <= '0;
      r_cnt    <= '0;
      r_mode   <= MODE_OFF;
      r_period <= '0;
      r_weff   <= '0;
      r_burst  <= '0;
      r_mask   <= '0;
      r_pulse  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_busy  <= (w_state_nxt == S_ARM) || (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_mode   <= cfg_mode_i;
        r_period <= w_per_clamp;
        r_weff   <= w_weff;
        r_burst  <= (cfg_mode_i == MODE_SINGLE) ? BURST_BITS'(1) : cfg_burst_i;
        r_mask   <= cfg_mask_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_pulse_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (start_i && !stop_i && (cfg_mode_i != MODE_OFF)) begin
          w_state_nxt = S_ARM;
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_pcnt_nxt  = '0;
        end
      end
      S_ARM: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_sync) begin
          w_pcnt_nxt  = '0;
          w_state_nxt = (!w_is_cont && (r_burst == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_pcnt == r_period) begin
          // Last (always low) cycle of the period; with sync alignment the
          // counter parks here until the next sync.
          if (w_sync) begin
            w_pcnt_nxt = '0;
            w_cnt_nxt  = w_cnt_inc;
            if (!w_is_cont && (w_cnt_inc == r_burst))
              w_state_nxt = S_DONE;
          end
        end else begin
          w_pcnt_nxt = r_pcnt + PERIOD_BITS'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Output is registered from the next counter value so RUN's first cycle
    // already shows the pulse.
    if (w_state_nxt == S_RUN)
      w_pulse_nxt = r_mask & {NUM_CH{CW'(w_pcnt_nxt) < r_weff}};
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pulse_cnt_o = r_cnt;
  assign pulse_o     = r_pulse;

endmodule

// File: tb/tb_radiant_pulse_gen.sv
module tb_radiant_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = '0;
  logic [23:0] period = '0;
  logic [15:0] width = '0;
  logic [15:0] burst = '0;
  logic [1:0]  mask = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done;
  logic [15:0] cnt;
  logic [1:0]  pulse;

  radiant_pulse_gen dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cfg_mode_i(mode), .cfg_period_i(period), .cfg_width_i(width),
    .cfg_burst_i(burst), .cfg_mask_i(mask),
    .start_i(start), .stop_i(stop),
    .busy_o(busy), .done_o(done), .pulse_cnt_o(cnt), .pulse_o(pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [1:0]  p;
    logic        b;
    logic        d;
    logic [15:0] n;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  // Monitor: counts edges and compares every expectation due this cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.c < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.c, cyc);
      end else if (pulse !== e.p || busy !== e.b || done !== e.d || cnt !== e.n) begin
        errors++;
        $display("FAIL %s cyc=%0d got pulse=%b busy=%b done=%b cnt=%0d, want pulse=%b busy=%b done=%b cnt=%0d",
                 e.nm, cyc, pulse, busy, done, cnt, e.p, e.b, e.d, e.n);
      end
    end
  end

  task automatic push(input int c, input logic [1:0] p, input logic b, input logic d,
                      input logic [15:0] n, input string nm);
    exp_t e;
    e.c = c; e.p = p; e.b = b; e.d = d; e.n = n; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
    end
  endtask

  task automatic kick(input logic [1:0] m, input int per, input int wid, input int bst,
                      input logic [1:0] mk, output int k);
    @(negedge clk);
    mode = m; period = 24'(per); width = 16'(wid); burst = 16'(bst); mask = mk;
    start = 1'b1;
    k = cyc;
  endtask

  // Expected train after a start at cycle k. p1 = period length in cycles,
  // w = effective high time, nb = pulses (-1: continuous for ncyc cycles).
  task automatic exp_run(input int k, input int p1, input int w, input logic [1:0] m,
                         input int nb, input int ncyc, input string nm);
    int len;
    push(k + 1, 2'b00, 1'b1, 1'b0, 16'd0, {nm, " arm"});
    if (nb == 0) begin
      push(k + 2, 2'b00, 1'b0, 1'b1, 16'd0, {nm, " done"});
      push(k + 3, 2'b00, 1'b0, 1'b0, 16'd0, {nm, " idle"});
    end else begin
      len = (nb > 0) ? nb * p1 : ncyc;
      for (int i = 0; i < len; i++)
        push(k + 2 + i, ((i % p1) < w) ? m : 2'b00, 1'b1, 1'b0, 16'(i / p1), {nm, " run"});
      if (nb > 0) begin
        push(k + 2 + len, 2'b00, 1'b0, 1'b1, 16'(nb), {nm, " done"});
        push(k + 3 + len, 2'b00, 1'b0, 1'b0, 16'(nb), {nm, " idle"});
      end
    end
  endtask

  initial begin
    int k;
    int c;
    // Reset state
    tick(2);
    c = cyc;
    push(c + 1, 2'b00, 1'b0, 1'b0, 16'd0, "reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Continuous: period 10, high 3, both channels; then stop
    kick(2'd1, 9, 3, 0, 2'b11, k);
    exp_run(k, 10, 3, 2'b11, -1, 25, "cont");
    tick(26);
    stop = 1'b1;
    c = cyc;
    push(c + 1, 2'b00, 1'b0, 1'b0, 16'd2, "cont stop");
    push(c + 2, 2'b00, 1'b0, 1'b0, 16'd2, "cont stop idle");
    tick(3);

    // Burst of 4, period 5, high 2, channel 0 only
    kick(2'd2, 4, 2, 4, 2'b01, k);
    exp_run(k, 5, 2, 2'b01, 4, 0, "burst4");
    tick(25);

    // Width 20 > period 5: high 5, low 1
    kick(2'd2, 5, 20, 2, 2'b10, k);
    exp_run(k, 6, 5, 2'b10, 2, 0, "wclamp");
    tick(17);

    // Width 0: never high, count still advances
    kick(2'd2, 3, 0, 2, 2'b11, k);
    exp_run(k, 4, 0, 2'b11, 2, 0, "w0");
    tick(13);

    // Period 0 clamped to 2-cycle period
    kick(2'd2, 0, 1, 3, 2'b11, k);
    exp_run(k, 2, 1, 2'b11, 3, 0, "p0");
    tick(11);

    // Single shot ignores burst config
    kick(2'd3, 3, 1, 5, 2'b11, k);
    exp_run(k, 4, 1, 2'b11, 1, 0, "single");
    tick(9);

    // Single aborted mid-pulse
    kick(2'd3, 7, 4, 1, 2'b11, k);
    exp_run(k, 8, 4, 2'b11, -1, 3, "abort");
    tick(4);
    stop = 1'b1;
    c = cyc;
    push(c + 1, 2'b00, 1'b0, 1'b0, 16'd0, "abort stop");
    push(c + 2, 2'b00, 1'b0, 1'b0, 16'd0, "abort no done");
    tick(3);

    // Start and stop together: stop wins
    @(negedge clk);
    mode = 2'd2; period = 24'd3; width = 16'd1; burst = 16'd1; mask = 2'b11;
    start = 1'b1; stop = 1'b1;
    c = cyc;
    push(c + 1, 2'b00, 1'b0, 1'b0, 16'd0, "startstop 1");
    push(c + 2, 2'b00, 1'b0, 1'b0, 16'd0, "startstop 2");
    push(c + 3, 2'b00, 1'b0, 1'b0, 16'd0, "startstop 3");
    tick(4);

    // Burst 1 to get a nonzero count, then start in mode 0 is ignored
    kick(2'd2, 1, 1, 1, 2'b11, k);
    exp_run(k, 2, 1, 2'b11, 1, 0, "pre");
    tick(6);
    kick(2'd0, 3, 1, 2, 2'b11, k);
    push(k + 1, 2'b00, 1'b0, 1'b0, 16'd1, "mode0 1");
    push(k + 2, 2'b00, 1'b0, 1'b0, 16'd1, "mode0 2");
    tick(3);

    // Burst 0: done at t+2, no pulse
    kick(2'd2, 4, 2, 0, 2'b11, k);
    exp_run(k, 5, 2, 2'b11, 0, 0, "b0");
    tick(4);

    // Config change and restart attempt while busy have no effect
    kick(2'd2, 4, 2, 2, 2'b11, k);
    exp_run(k, 5, 2, 2'b11, 2, 0, "shadow");
    tick(4);
    mode = 2'd1; period = 24'd1; width = 16'd0; mask = 2'b00; burst = 16'd9;
    start = 1'b1;
    tick(12);

    // Reset during RUN
    kick(2'd1, 2, 1, 3, 2'b11, k);
    exp_run(k, 3, 1, 2'b11, -1, 8, "rstrun");
    tick(9);
    rst_n = 1'b0;
    c = cyc;
    push(c + 1, 2'b00, 1'b0, 1'b0, 16'd0, "rst mid");
    tick(1);
    rst_n = 1'b1;
    push(c + 2, 2'b00, 1'b0, 1'b0, 16'd0, "rst after");
    tick(5);

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
